// File: rtl/change_dispenser.sv
// Purpose: pays out change greedily (5, 2, then 1 zl coins) as timed one-hot solenoid pulses.
// Latency: each coin takes 1+PULSE_CYC+GAP_CYC cycles; done is 1 cycle after the last GAP, or after a failed SELECT.
// Backpressure: change_ready is high only in IDLE with refill low, so a held request waits until the payout finishes.
//
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   change_valid, change_amt            payout request (amount in zl)
//   change_ready                        request accepted when valid && ready
//   refill                              reload all hoppers (honoured in IDLE only)
//   Coin_out                            one-hot eject: [0] 1 zl, [1] 2 zl, [2] 5 zl
//   busy, done                          payout in progress / one-cycle completion strobe
//   short, owed                         last payout incomplete / unpaid residue
//   empty1, empty2, empty5              hopper count == 0
module change_dispenser #(
    parameter int AMT_W     = 8,
    parameter int CNT_W     = 8,
    parameter int INIT_CNT1 = 20,
    parameter int INIT_CNT2 = 20,
    parameter int INIT_CNT5 = 20,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amt,
    output logic             change_ready,
    input  logic             refill,
    output logic [2:0]       Coin_out,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] owed,
    output logic             empty1,
    output logic             empty2,
    output logic             empty5
);

    typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

    localparam int TMR_W = 16;

    state_t           state;
    logic [AMT_W-1:0] remaining;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic [CNT_W-1:0] cnt5;

    assign change_ready = (state == IDLE) && !refill;
    assign busy         = (state != IDLE);
    assign empty1       = (cnt1 == '0);
    assign empty2       = (cnt2 == '0);
    assign empty5       = (cnt5 == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            tmr       <= '0;
            cnt1      <= CNT_W'(INIT_CNT1);
            cnt2      <= CNT_W'(INIT_CNT2);
            cnt5      <= CNT_W'(INIT_CNT5);
            Coin_out  <= '0;
            done      <= 1'b0;
            short     <= 1'b0;
            owed      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Refill takes priority; change_ready is low in that cycle.
                    if (refill) begin
                        cnt1 <= CNT_W'(INIT_CNT1);
                        cnt2 <= CNT_W'(INIT_CNT2);
                        cnt5 <= CNT_W'(INIT_CNT5);
                    end else if (change_valid) begin
                        remaining <= change_amt;
                        short     <= 1'b0;
                        owed      <= '0;
                        if (change_amt == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= SELECT;
                        end
                    end
                end
                SELECT: begin
                    // Strictly greedy: no backtracking when a smaller hopper is empty.
                    if (remaining >= AMT_W'(5) && cnt5 != '0) begin
                        remaining <= remaining - AMT_W'(5);
                        cnt5      <= cnt5 - CNT_W'(1);
                        Coin_out  <= 3'b100;
                        state     <= PULSE;
                    end else if (remaining >= AMT_W'(2) && cnt2 != '0) begin
                        remaining <= remaining - AMT_W'(2);
                        cnt2      <= cnt2 - CNT_W'(1);
                        Coin_out  <= 3'b010;
                        state     <= PULSE;
                    end else if (remaining >= AMT_W'(1) && cnt1 != '0) begin
                        remaining <= remaining - AMT_W'(1);
                        cnt1      <= cnt1 - CNT_W'(1);
                        Coin_out  <= 3'b001;
                        state     <= PULSE;
                    end else begin
                        short <= 1'b1;
                        owed  <= remaining;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                PULSE: begin
                    // Coin_out was loaded on entry, so it is high for exactly PULSE_CYC cycles.
                    if (tmr == TMR_W'(PULSE_CYC - 1)) begin
                        tmr      <= '0;
                        Coin_out <= '0;
                        state    <= GAP;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                GAP: begin
                    if (tmr == TMR_W'(GAP_CYC - 1)) begin
                        tmr <= '0;
                        if (remaining != '0) begin
                            state <= SELECT;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Pays out change from the vending machine's coin hoppers. It accepts a change amount over a valid/ready handshake and ejects coins greedily (5 zł, then 2 zł, then 1 zł) as timed one-hot solenoid pulses on `Coin_out`. `Coin_out` uses the same bit encoding as the machine's `Money_in`. The block tracks the inventory of each hopper and reports any amount it could not pay.

## Interface
- `AMT_W`, 8, width of change amount and owed residue
- `CNT_W`, 8, width of each hopper inventory counter
- `INIT_CNT1`, 20, 1 zł coins loaded at reset/refill
- `INIT_CNT2`, 20, 2 zł coins loaded at reset/refill
- `INIT_CNT5`, 20, 5 zł coins loaded at reset/refill
- `PULSE_CYC`, 4, cycles a solenoid bit stays high per coin (≥1)
- `GAP_CYC`, 2, low cycles after each pulse (≥1)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `change_valid`  in  1  request present
- `change_amt`  in  AMT_W  amount to pay, in zł
- `change_ready`  out  1  block can accept a request
- `refill`  in  1  reload all hoppers to their INIT values
- `Coin_out`  out  3  one-hot eject: [0] 1 zł, [1] 2 zł, [2] 5 zł
- `busy`  out  1  payout in progress
- `done`  out  1  one-cycle completion strobe
- `short`  out  1  last payout incomplete
- `owed`  out  AMT_W  unpaid residue of last payout
- `empty1`, `empty2`, `empty5`  out  1 each  hopper count == 0

## Operation
- FSM states: IDLE, SELECT, PULSE, GAP, DONE.
- **IDLE**
  - `change_ready` = (state==IDLE) && !`refill`.
  - If `refill` is high, all counters load their INIT values. Refill wins over a simultaneous `change_valid`.
  - `refill` is ignored in every other state.
  - On `change_valid` && `change_ready`:
    - Latch `remaining` = `change_amt`, clear `short` and `owed`.
    - If the amount is 0, go to DONE; otherwise go to SELECT.
- **SELECT**
  - Pick the largest coin d ∈ {5,2,1} with d ≤ `remaining` and that hopper's count > 0.
  - If a coin is found: `remaining` -= d, decrement its counter, latch the one-hot selection, go to PULSE.
  - If none is found: `short`=1, `owed`=`remaining`, go to DONE.
  - Selection is strictly greedy. No backtracking, e.g. 6 with the 1 zł hopper empty pays 5 and owes 1.
- **PULSE**: `Coin_out` = selection for exactly PULSE_CYC cycles, then go to GAP.
- **GAP**
  - `Coin_out`=0 for GAP_CYC cycles.
  - Then go to SELECT if `remaining` > 0, else to DONE.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- `short` and `owed` hold their value until the next accepted request.
- `busy` = (state != IDLE).
- Counters never underflow, because a hopper is only selected when its count > 0.
- `empty*` are decoded combinationally from the counters.
- All arithmetic is unsigned AMT_W. `remaining` never goes negative because d ≤ `remaining`.

## Timing
- Reset values: state IDLE, `Coin_out`=000, `done`=0, `short`=0, `owed`=0, `busy`=0, counters=INIT.
- `change_ready`=1 after reset unless `refill` is high.
- `reset_n` low at any time, including mid-PULSE:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - The payout in progress is abandoned, and no `done` strobe is produced for it.
- `Coin_out`, `done`, `short` and `owed` are registered. `change_ready`, `busy` and `empty*` are decoded from state and registers.
- Cycle numbering: the accepting edge is E0; cycle c1 is the cycle after E0.
  - SELECT occupies c1.
  - The pulse for coin i (1-based) is high during cycles c(k(i−1)+2) through c(k(i−1)+1+PULSE_CYC), where k = 1+PULSE_CYC+GAP_CYC.
  - For n coins paid in full, `done` is high in c(k·n+1).
  - With defaults k=7; amount 8 (coins 5,2,1) gives `done` in c22.
- Amount 0: `done` in c1, no pulses.
- Shortfall found in a SELECT at cycle cj: `done` is high in c(j+1).
- A new request can be accepted one cycle after `done` at the earliest.

## Test plan
1. Reset, `change_amt`=8 → `Coin_out` pulses 100, 010, 001, each 4 cycles with 2 low cycles between. `done` in c22, `short`=0, `owed`=0. Counters become 19/19/19.
2. `change_amt`=0 → no pulses, `done` in c1, `short`=0, counters unchanged.
3. INIT_CNT1=0, INIT_CNT2=1, `change_amt`=5 → one 100 pulse, `done`, `short`=0. Then `change_amt`=4 → one 010 pulse, `done`, `short`=1, `owed`=2, `empty1`=`empty2`=1.
4. `change_valid` held high with amount 3 through a running payout → `change_ready`=0 while `busy`. The second request is accepted in the cycle after `done` and pays 010 then 001.
5. `reset_n` driven low in the 2nd PULSE cycle of amount 7 → `Coin_out`=000 immediately, no `done`, counters back to 20/20/20. `change_ready`=1 after release.
6. Drain hopper 5 to 0, then assert `refill` and `change_valid` (amount 5) in the same IDLE cycle → request not accepted, counters reload to INIT, `empty5`=0. The request is accepted next cycle and pays 100.
